// File: rtl/sdp_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sdp_ram_arbiter
//  Description : Shares one simple dual-port RAM (write port A, read port B)
//                between two write clients and two read clients. Each port
//                has its own round-robin arbiter with req/gnt handshakes.
//                All RAM-side controls are registered. Read data is routed
//                back to the issuing client through a tag pipeline that
//                tracks the RAM read latency.
//                Optional macro SDP_RAM_ARB_INIT_EN adds a clear sequencer
//                that writes zero to every RAM address after reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdp_ram_arbiter #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_wr0_req,
   input  logic [ADDR_W-1:0] i_wr0_addr,
   input  logic [DATA_W-1:0] i_wr0_data,
   output logic              o_wr0_gnt,
   input  logic              i_wr1_req,
   input  logic [ADDR_W-1:0] i_wr1_addr,
   input  logic [DATA_W-1:0] i_wr1_data,
   output logic              o_wr1_gnt,
   input  logic              i_rd0_req,
   input  logic [ADDR_W-1:0] i_rd0_addr,
   output logic              o_rd0_gnt,
   output logic              o_rd0_valid,
   output logic [DATA_W-1:0] o_rd0_data,
   input  logic              i_rd1_req,
   input  logic [ADDR_W-1:0] i_rd1_addr,
   output logic              o_rd1_gnt,
   output logic              o_rd1_valid,
   output logic [DATA_W-1:0] o_rd1_data,
   output logic              o_ram_ena,
   output logic              o_ram_wea,
   output logic [ADDR_W-1:0] o_ram_addra,
   output logic [DATA_W-1:0] o_ram_dina,
   output logic              o_ram_enb,
   output logic [ADDR_W-1:0] o_ram_addrb,
   input  logic [DATA_W-1:0] i_ram_doutb,
   output logic              o_init_done
);

   logic              r_init_done;
   logic              w_seq_done;
   logic              w_clr_we;
   logic [ADDR_W-1:0] w_clr_addr;
   logic              w_run;

   logic              r_wr_ptr;
   logic              r_rd_ptr;
   logic              w_wr_gnt0;
   logic              w_wr_gnt1;
   logic              w_rd_gnt0;
   logic              w_rd_gnt1;

   logic              r_ram_ena;
   logic              r_ram_wea;
   logic [ADDR_W-1:0] r_ram_addra;
   logic [DATA_W-1:0] r_ram_dina;
   logic              r_ram_enb;
   logic [ADDR_W-1:0] r_ram_addrb;
   logic              r_rd_id;

   logic [RD_LAT-1:0] r_tag_vld;
   logic [RD_LAT-1:0] r_tag_id;

   logic              r_rd0_valid;
   logic              r_rd1_valid;
   logic [DATA_W-1:0] r_rd0_data;
   logic [DATA_W-1:0] r_rd1_data;

`ifdef SDP_RAM_ARB_INIT_EN
   localparam logic [ADDR_W-1:0] c_addr_last = '1;
   localparam logic [ADDR_W-1:0] c_addr_one  = {{(ADDR_W-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } init_state_t;

   init_state_t       r_state;
   init_state_t       w_state_nxt;
   logic [ADDR_W-1:0] r_clr_addr;
   logic [ADDR_W-1:0] w_clr_addr_nxt;

   // Clear-sequencer state and address registers; reset restarts at address 0
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= ST_CLEAR;
         r_clr_addr <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_clr_addr <= w_clr_addr_nxt;
      end
   end

   // Walk every address once, then hand port A over to the clients
   always_comb begin
      w_state_nxt    = r_state;
      w_clr_addr_nxt = r_clr_addr;
      if (r_state == ST_CLEAR) begin
         w_clr_addr_nxt = r_clr_addr + c_addr_one;
         if (r_clr_addr == c_addr_last) begin
            w_state_nxt = ST_RUN;
         end
      end
   end

   assign w_clr_we   = (r_state == ST_CLEAR);
   assign w_clr_addr = r_clr_addr;
   assign w_seq_done = (r_state == ST_RUN);
`else
   assign w_clr_we   = 1'b0;
   assign w_clr_addr = '0;
   assign w_seq_done = 1'b1;
`endif

   // Clients are served once the block is out of reset and any clear is finished
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_init_done <= 1'b0;
      end else begin
         r_init_done <= w_seq_done;
      end
   end

   // Reset is folded in so no grant can appear while reset is held
   assign w_run = r_init_done & ~i_rst;

   // Round-robin: a lone requester wins; on contention the pointer's client wins
   assign w_wr_gnt0 = w_run & i_wr0_req & (~i_wr1_req | ~r_wr_ptr);
   assign w_wr_gnt1 = w_run & i_wr1_req & (~i_wr0_req |  r_wr_ptr);
   assign w_rd_gnt0 = w_run & i_rd0_req & (~i_rd1_req | ~r_rd_ptr);
   assign w_rd_gnt1 = w_run & i_rd1_req & (~i_rd0_req |  r_rd_ptr);

   // Any grant hands priority to the other client next time
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
      end else begin
         if (w_wr_gnt0) begin
            r_wr_ptr <= 1'b1;
         end else if (w_wr_gnt1) begin
            r_wr_ptr <= 1'b0;
         end
         if (w_rd_gnt0) begin
            r_rd_ptr <= 1'b1;
         end else if (w_rd_gnt1) begin
            r_rd_ptr <= 1'b0;
         end
      end
   end

   // Port A controls: clear sequencer has priority, address/data hold when idle
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ram_ena   <= 1'b0;
         r_ram_wea   <= 1'b0;
         r_ram_addra <= '0;
         r_ram_dina  <= '0;
      end else if (w_clr_we) begin
         r_ram_ena   <= 1'b1;
         r_ram_wea   <= 1'b1;
         r_ram_addra <= w_clr_addr;
         r_ram_dina  <= '0;
      end else if (w_wr_gnt0 | w_wr_gnt1) begin
         r_ram_ena   <= 1'b1;
         r_ram_wea   <= 1'b1;
         r_ram_addra <= w_wr_gnt0 ? i_wr0_addr : i_wr1_addr;
         r_ram_dina  <= w_wr_gnt0 ? i_wr0_data : i_wr1_data;
      end else begin
         r_ram_ena   <= 1'b0;
         r_ram_wea   <= 1'b0;
      end
   end

   // Port B controls plus the id of the client that issued this read
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ram_enb   <= 1'b0;
         r_ram_addrb <= '0;
         r_rd_id     <= 1'b0;
      end else if (w_rd_gnt0 | w_rd_gnt1) begin
         r_ram_enb   <= 1'b1;
         r_ram_addrb <= w_rd_gnt0 ? i_rd0_addr : i_rd1_addr;
         r_rd_id     <= w_rd_gnt1;
      end else begin
         r_ram_enb   <= 1'b0;
      end
   end

   // Tag shift register follows each read through the RAM latency
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_tag_vld <= '0;
         r_tag_id  <= '0;
      end else begin
         r_tag_vld[0] <= r_ram_enb;
         r_tag_id[0]  <= r_rd_id;
         for (int i = 1; i < RD_LAT; i++) begin
            r_tag_vld[i] <= r_tag_vld[i-1];
            r_tag_id[i]  <= r_tag_id[i-1];
         end
      end
   end

   // Steer RAM output to the owning client; data holds between valids
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rd0_valid <= 1'b0;
         r_rd1_valid <= 1'b0;
         r_rd0_data  <= '0;
         r_rd1_data  <= '0;
      end else begin
         r_rd0_valid <= r_tag_vld[RD_LAT-1] & ~r_tag_id[RD_LAT-1];
         r_rd1_valid <= r_tag_vld[RD_LAT-1] &  r_tag_id[RD_LAT-1];
         if (r_tag_vld[RD_LAT-1] & ~r_tag_id[RD_LAT-1]) begin
            r_rd0_data <= i_ram_doutb;
         end
         if (r_tag_vld[RD_LAT-1] & r_tag_id[RD_LAT-1]) begin
            r_rd1_data <= i_ram_doutb;
         end
      end
   end

   assign o_wr0_gnt   = w_wr_gnt0;
   assign o_wr1_gnt   = w_wr_gnt1;
   assign o_rd0_gnt   = w_rd_gnt0;
   assign o_rd1_gnt   = w_rd_gnt1;
   assign o_rd0_valid = r_rd0_valid;
   assign o_rd1_valid = r_rd1_valid;
   assign o_rd0_data  = r_rd0_data;
   assign o_rd1_data  = r_rd1_data;
   assign o_ram_ena   = r_ram_ena;
   assign o_ram_wea   = r_ram_wea;
   assign o_ram_addra = r_ram_addra;
   assign o_ram_dina  = r_ram_dina;
   assign o_ram_enb   = r_ram_enb;
   assign o_ram_addrb = r_ram_addrb;
   assign o_init_done = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_sdp_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdp_ram_arbiter
//  Description : Self-checking bench for sdp_ram_arbiter with a RAM model,
//                a transaction-level reference model and randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdp_ram_arbiter;
   localparam int ADDR_W = 4;
   localparam int DATA_W = 32;
   localparam int RD_LAT = 1;
   localparam int DEPTH  = 1 << ADDR_W;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst = 1'b1;
   logic              wreq [2];
   logic [ADDR_W-1:0] waddr[2];
   logic [DATA_W-1:0] wdata[2];
   logic              rreq [2];
   logic [ADDR_W-1:0] raddr[2];

   logic              wr0_gnt, wr1_gnt, rd0_gnt, rd1_gnt;
   logic              rd0_valid, rd1_valid;
   logic [DATA_W-1:0] rd0_data, rd1_data;
   logic              ram_ena, ram_wea, ram_enb, init_done;
   logic [ADDR_W-1:0] ram_addra, ram_addrb;
   logic [DATA_W-1:0] ram_dina, ram_doutb;

   sdp_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_wr0_req(wreq[0]), .i_wr0_addr(waddr[0]), .i_wr0_data(wdata[0]), .o_wr0_gnt(wr0_gnt),
      .i_wr1_req(wreq[1]), .i_wr1_addr(waddr[1]), .i_wr1_data(wdata[1]), .o_wr1_gnt(wr1_gnt),
      .i_rd0_req(rreq[0]), .i_rd0_addr(raddr[0]), .o_rd0_gnt(rd0_gnt),
      .o_rd0_valid(rd0_valid), .o_rd0_data(rd0_data),
      .i_rd1_req(rreq[1]), .i_rd1_addr(raddr[1]), .o_rd1_gnt(rd1_gnt),
      .o_rd1_valid(rd1_valid), .o_rd1_data(rd1_data),
      .o_ram_ena(ram_ena), .o_ram_wea(ram_wea), .o_ram_addra(ram_addra), .o_ram_dina(ram_dina),
      .o_ram_enb(ram_enb), .o_ram_addrb(ram_addrb), .i_ram_doutb(ram_doutb),
      .o_init_done(init_done)
   );

   // Read-first RAM with RD_LAT cycles from registered enb/addrb to doutb
   logic [DATA_W-1:0] ram [DEPTH];
   logic [DATA_W-1:0] ram_pipe [RD_LAT];
   always @(posedge clk) begin
      if (ram_ena && ram_wea) ram[ram_addra] <= ram_dina;
      if (ram_enb) ram_pipe[0] <= ram[ram_addrb];
      for (int i = 1; i < RD_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
   end
   assign ram_doutb = ram_pipe[RD_LAT-1];

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [DATA_W-1:0] ref_mem [DEPTH];
   logic              m_known = 1'b0;
   logic              m_done, m_wptr, m_rptr;
   logic              m_ena, m_wea, m_enb;
   logic [ADDR_W-1:0] m_addra, m_addrb;
   logic [DATA_W-1:0] m_dina;
   logic [DATA_W-1:0] m_rd [2];
   logic              sv [8];
   logic              sid [8];
   logic [DATA_W-1:0] sdata [8];
   logic              acc_w [2];
   logic              acc_r [2];
   int                cyc = 0;

   initial begin : compare
      logic run, gw0, gw1, gr0, gr1, ev0, ev1;
      logic [ADDR_W-1:0] a;
      int idx, slot;
      forever begin
         @(negedge clk);
         idx = cyc % 8;
         ev0 = sv[idx] && !sid[idx];
         ev1 = sv[idx] &&  sid[idx];
         if (ev0) m_rd[0] = sdata[idx];
         if (ev1) m_rd[1] = sdata[idx];
         sv[idx] = 1'b0;
         if (m_known) begin
            chk("init_done", 64'(init_done), 64'(m_done));
            chk("ram_ena",   64'(ram_ena),   64'(m_ena));
            chk("ram_wea",   64'(ram_wea),   64'(m_wea));
            chk("ram_addra", 64'(ram_addra), 64'(m_addra));
            chk("ram_dina",  64'(ram_dina),  64'(m_dina));
            chk("ram_enb",   64'(ram_enb),   64'(m_enb));
            chk("ram_addrb", 64'(ram_addrb), 64'(m_addrb));
            chk("rd0_valid", 64'(rd0_valid), 64'(ev0));
            chk("rd1_valid", 64'(rd1_valid), 64'(ev1));
            chk("rd0_data",  64'(rd0_data),  64'(m_rd[0]));
            chk("rd1_data",  64'(rd1_data),  64'(m_rd[1]));
         end
         run = m_known && m_done && !rst;
         gw0 = run && wreq[0] && (!wreq[1] || !m_wptr);
         gw1 = run && wreq[1] && (!wreq[0] ||  m_wptr);
         gr0 = run && rreq[0] && (!rreq[1] || !m_rptr);
         gr1 = run && rreq[1] && (!rreq[0] ||  m_rptr);
         if (m_known) begin
            chk("wr0_gnt", 64'(wr0_gnt), 64'(gw0));
            chk("wr1_gnt", 64'(wr1_gnt), 64'(gw1));
            chk("rd0_gnt", 64'(rd0_gnt), 64'(gr0));
            chk("rd1_gnt", 64'(rd1_gnt), 64'(gr1));
         end
         acc_w[0] = gw0; acc_w[1] = gw1;
         acc_r[0] = gr0; acc_r[1] = gr1;
         if (rst) begin
            m_known = 1'b1;
            m_done = 1'b0; m_wptr = 1'b0; m_rptr = 1'b0;
            m_ena = 1'b0; m_wea = 1'b0; m_enb = 1'b0;
            m_addra = '0; m_addrb = '0; m_dina = '0;
            m_rd[0] = '0; m_rd[1] = '0;
            for (int i = 0; i < 8; i++) sv[i] = 1'b0;
         end else if (m_known) begin
            m_done = 1'b1;
            if (gr0 || gr1) begin
               a = gr0 ? raddr[0] : raddr[1];
               m_enb = 1'b1; m_addrb = a;
               slot = (cyc + 2 + RD_LAT) % 8;
               sv[slot] = 1'b1; sid[slot] = gr1; sdata[slot] = ref_mem[a];
               m_rptr = gr0;
            end else begin
               m_enb = 1'b0;
            end
            if (gw0 || gw1) begin
               m_ena = 1'b1; m_wea = 1'b1;
               m_addra = gw0 ? waddr[0] : waddr[1];
               m_dina  = gw0 ? wdata[0] : wdata[1];
               ref_mem[m_addra] = m_dina;
               m_wptr = gw0;
            end else begin
               m_ena = 1'b0; m_wea = 1'b0;
            end
         end
         cyc++;
      end
   end

   // ---------------- stimulus ----------------
   logic rnd = 1'b0;

   task automatic tick();
      @(posedge clk);
      #1;
      for (int c = 0; c < 2; c++) begin
         if (acc_w[c]) wreq[c] = 1'b0;
         if (acc_r[c]) rreq[c] = 1'b0;
      end
      if (rnd) begin
         rst = ($urandom_range(0, 399) == 0);
         for (int c = 0; c < 2; c++) begin
            if (!wreq[c] && $urandom_range(0, 2) != 0) begin
               wreq[c] = 1'b1; waddr[c] = ADDR_W'($urandom); wdata[c] = $urandom;
            end
            if (!rreq[c] && $urandom_range(0, 2) != 0) begin
               rreq[c] = 1'b1; raddr[c] = ADDR_W'($urandom);
            end
         end
      end
   endtask

   task automatic do_write(input int c, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      int n = 0;
      wreq[c] = 1'b1; waddr[c] = a; wdata[c] = d;
      while (wreq[c] && n < 20) begin tick(); n++; end
      chk("wr_accept", 64'(wreq[c]), 64'(0));
   endtask

   task automatic do_read(input int c, input logic [ADDR_W-1:0] a);
      int n = 0;
      rreq[c] = 1'b1; raddr[c] = a;
      while (rreq[c] && n < 20) begin tick(); n++; end
      chk("rd_accept", 64'(rreq[c]), 64'(0));
   endtask

   task automatic wait_valid(input int c, output int lat, output logic [DATA_W-1:0] d, output logic other);
      logic v = 1'b0;
      lat = 0; other = 1'b0; d = '0;
      while (!v && lat < 10) begin
         tick(); lat++;
         v = (c == 0) ? rd0_valid : rd1_valid;
         other = other | ((c == 0) ? rd1_valid : rd0_valid);
      end
      d = (c == 0) ? rd0_data : rd1_data;
      chk("valid_seen", 64'(v), 64'(1));
   endtask

   task automatic drain();
      int n = 0;
      while ((wreq[0] || wreq[1] || rreq[0] || rreq[1]) && n < 30) begin tick(); n++; end
      repeat (4) tick();
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int lat;
      logic [DATA_W-1:0] d;
      logic other, saw;
      logic [5:0] seq1, seq0;
      int idx[2], cnt[2];
      for (int i = 0; i < DEPTH; i++) begin ram[i] = '0; ref_mem[i] = '0; end
      for (int i = 0; i < RD_LAT; i++) ram_pipe[i] = '0;
      for (int i = 0; i < 8; i++) sv[i] = 1'b0;
      for (int c = 0; c < 2; c++) begin
         wreq[c] = 1'b0; waddr[c] = '0; wdata[c] = '0; rreq[c] = 1'b0; raddr[c] = '0;
         acc_w[c] = 1'b0; acc_r[c] = 1'b0;
      end
      rst = 1'b1;
      repeat (3) tick();
      chk("rst_init_done", 64'(init_done), 64'(0));
      chk("rst_outs_zero", 64'(|{ram_ena, ram_wea, ram_addra, ram_dina, ram_enb, ram_addrb,
                                 rd0_valid, rd1_valid, rd0_data, rd1_data}), 64'(0));
      rst = 1'b0;
      tick();
      chk("init_done_after_rst", 64'(init_done), 64'(1));

      // both write clients contend continuously
      for (int k = 0; k < 6; k++) begin
         for (int c = 0; c < 2; c++) begin
            if (!wreq[c]) begin
               wreq[c] = 1'b1; waddr[c] = ADDR_W'(c * 8 + k); wdata[c] = $urandom;
            end
         end
         @(negedge clk); #1;
         seq1[k] = wr1_gnt; seq0[k] = wr0_gnt;
         tick();
      end
      chk("alt_wr1_gnt", 64'(seq1), 64'(6'b101010));
      chk("alt_wr0_gnt", 64'(seq0), 64'(6'b010101));
      drain();

      // write then read back through the other read client
      do_write(0, 4'd5, 32'hDEADBEEF);
      do_read(1, 4'd5);
      wait_valid(1, lat, d, other);
      chk("rd1_latency", 64'(lat), 64'(1 + RD_LAT));
      chk("rd1_data_lit", 64'(d), 64'h0000_0000_DEAD_BEEF);
      chk("rd0_quiet", 64'(other), 64'(0));

      // same-cycle write and read of one address returns old data
      do_write(0, 4'd3, 32'h7);
      drain();
      wreq[1] = 1'b1; waddr[1] = 4'd3; wdata[1] = 32'h1;
      rreq[0] = 1'b1; raddr[0] = 4'd3;
      tick();
      chk("same_cycle_accept", 64'({wreq[1], rreq[0]}), 64'(0));
      wait_valid(0, lat, d, other);
      chk("read_first_old", 64'(d), 64'h7);
      do_read(0, 4'd3);
      wait_valid(0, lat, d, other);
      chk("read_after_new", 64'(d), 64'h1);

      // streaming reads from both clients over pre-written addresses
      for (int i = 0; i < 8; i++) do_write(0, ADDR_W'(i), DATA_W'(i));
      drain();
      idx[0] = 0; idx[1] = 0; cnt[0] = 0; cnt[1] = 0;
      for (int n = 0; n < 30; n++) begin
         for (int c = 0; c < 2; c++) begin
            if (!rreq[c] && idx[c] < 8) begin
               rreq[c] = 1'b1; raddr[c] = ADDR_W'(idx[c]); idx[c]++;
            end
         end
         tick();
         cnt[0] += int'(rd0_valid); cnt[1] += int'(rd1_valid);
      end
      chk("stream_cnt0", 64'(cnt[0]), 64'(8));
      chk("stream_cnt1", 64'(cnt[1]), 64'(8));

      // reset one cycle after a read is accepted discards it
      do_read(0, 4'd5);
      rst = 1'b1;
      saw = 1'b0;
      repeat (3) begin tick(); saw = saw | rd0_valid | rd1_valid; end
      chk("rst_mid_outs_zero", 64'(|{ram_ena, ram_wea, ram_addra, ram_dina, ram_enb, ram_addrb,
                                     rd0_valid, rd1_valid, rd0_data, rd1_data, init_done}), 64'(0));
      rst = 1'b0;
      repeat (4) begin tick(); saw = saw | rd0_valid | rd1_valid; end
      chk("no_valid_after_rst", 64'(saw), 64'(0));

      // randomized traffic with occasional resets
      rnd = 1'b1;
      repeat (2000) tick();
      rnd = 1'b0;
      rst = 1'b0;
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
`default_nettype wire
